// File: rtl/mul256_sched.sv
// mul256_sched: 256x256 -> 512-bit multiplier sequencer driving one external
// 64x64 multiplier. It issues all 16 limb pairs in 16 cycles, then waits
// MUL_LAT cycles for the last product to return, and pulses done.
module mul256_sched #(
   parameter int unsigned MUL_LAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] a,
   input  logic [255:0] b,
   output logic         busy,
   output logic         done,
   output logic [511:0] c,
   output logic [63:0]  mul_a,
   output logic [63:0]  mul_b,
   input  logic [127:0] mul_p
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [3:0]     k;
   logic [2:0]     dcnt;
   logic [255:0]   a_lat;
   logic [255:0]   b_lat;
   logic           accept;

   // Tag of the limb pair issued this cycle: valid bit and limb shift i+j.
   logic           issue_v;
   logic [2:0]     issue_sh;

   // Tag of the product present on mul_p this cycle.
   logic           ret_v;
   logic [2:0]     ret_sh;

   logic [511:0]   addend;

   assign accept = (state == IDLE) && start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode plus the limb multiplexers and status outputs.
   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = 1'b0;
      mul_a    = '0;
      mul_b    = '0;
      issue_v  = 1'b0;
      issue_sh = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            issue_v  = 1'b1;
            issue_sh = {1'b0, k[3:2]} + {1'b0, k[1:0]};
            mul_a    = a_lat[{k[3:2], 6'b0} +: 64];
            mul_b    = b_lat[{k[1:0], 6'b0} +: 64];
            if (k == 4'd15) begin
               state_nx = (MUL_LAT > 0) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            if (dcnt == 3'(MUL_LAT - 1)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Tag delay line matching the external multiplier latency.
   if (MUL_LAT == 0) begin : g_nodly
      assign ret_v  = issue_v;
      assign ret_sh = issue_sh;
   end else begin : g_dly
      logic [MUL_LAT-1:0] dv;
      logic [2:0]         ds [MUL_LAT];

      // Shift issued tags one stage per cycle; stage MUL_LAT-1 lines up with mul_p.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dv <= '0;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
               ds[s] <= '0;
            end
         end else begin
            dv[0] <= issue_v;
            ds[0] <= issue_sh;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
               dv[s] <= dv[s-1];
               ds[s] <= ds[s-1];
            end
         end
      end

      assign ret_v  = dv[MUL_LAT-1];
      assign ret_sh = ds[MUL_LAT-1];
   end

   // Align the returning partial product to limb position 64*(i+j).
   always_comb begin
      addend = {384'b0, mul_p} << {ret_sh, 6'b0};
   end

   // Operand latches and product accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat <= '0;
         b_lat <= '0;
         c     <= '0;
      end else if (accept) begin
         a_lat <= a;
         b_lat <= b;
         c     <= '0;
      end else if (ret_v) begin
         c <= c + addend;
      end
   end

   // Issue index and drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k    <= '0;
         dcnt <= '0;
      end else begin
         if (accept) begin
            k <= '0;
         end else if (state == ISSUE) begin
            k <= k + 4'd1;
         end
         if (state == DRAIN) begin
            dcnt <= dcnt + 3'd1;
         end else begin
            dcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mul256_sched.sv
// Testbench for mul256_sched: one instance with MUL_LAT=0 and one with
// MUL_LAT=2, each fed by a behavioural 64x64 multiplier of matching latency.
module tb_mul256_sched;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         start0 = 1'b0;
   logic         start2 = 1'b0;
   logic [255:0] a      = '0;
   logic [255:0] b      = '0;

   logic         busy0, done0, busy2, done2;
   logic [511:0] c0, c2;
   logic [63:0]  ma0, mb0, ma2, mb2;
   logic [127:0] mp0, mp2, p2a, p2b;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit           l2;
      logic [255:0] a;
      logic [255:0] b;
      logic [511:0] exp;
   } vec_t;

   vec_t tbl[8];

   localparam logic [255:0] BV =
      256'hDEADBEEF_00000000_12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0_01234567_89ABCDEF;
   localparam logic [255:0] ONES = {256{1'b1}};

   always #5 clk = ~clk;

   mul256_sched #(.MUL_LAT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start0),
      .a     (a),
      .b     (b),
      .busy  (busy0),
      .done  (done0),
      .c     (c0),
      .mul_a (ma0),
      .mul_b (mb0),
      .mul_p (mp0)
   );

   mul256_sched #(.MUL_LAT(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start2),
      .a     (a),
      .b     (b),
      .busy  (busy2),
      .done  (done2),
      .c     (c2),
      .mul_a (ma2),
      .mul_b (mb2),
      .mul_p (mp2)
   );

   // Combinational multiplier for the MUL_LAT=0 instance.
   assign mp0 = {64'b0, ma0} * {64'b0, mb0};

   // Two-stage pipelined multiplier for the MUL_LAT=2 instance.
   always @(posedge clk) begin
      p2a <= {64'b0, ma2} * {64'b0, mb2};
      p2b <= p2a;
   end
   assign mp2 = p2b;

   function automatic logic [511:0] mul(input logic [255:0] x, input logic [255:0] y);
      return {256'b0, x} * {256'b0, y};
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: no done within cycle budget", nm);
   endtask

   // One operation on the selected instance; checks limbs, latency, result, return to idle.
   task automatic run_op(input bit l2, input logic [255:0] x, input logic [255:0] y,
                         input logic [511:0] exp, input bit chk_limbs, input string nm);
      int n;
      int k;
      int lat;
      bit got;
      lat = l2 ? 2 : 0;
      @(negedge clk);
      a = x;
      b = y;
      if (l2) start2 = 1'b1;
      else    start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      n   = 1;
      got = 1'b0;
      while (!got && n <= 40) begin
         if (n == 1) check({nm, "_busy"}, l2 ? busy2 : busy0, 1);
         if (chk_limbs && n <= 16) begin
            k = n - 1;
            check({nm, "_mula"}, l2 ? ma2 : ma0, x[64*(k/4) +: 64]);
            check({nm, "_mulb"}, l2 ? mb2 : mb0, y[64*(k%4) +: 64]);
         end
         if (l2 ? done2 : done0) begin
            got = 1'b1;
            check({nm, "_lat"}, n, 17 + lat);
            check({nm, "_c"}, l2 ? c2 : c0, exp);
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (!got) timeout({nm, "_timeout"});
      @(negedge clk);
      check({nm, "_idle"},
            {l2 ? done2 : done0, l2 ? busy2 : busy0, l2 ? ma2 : ma0, l2 ? mb2 : mb0}, '0);
      check({nm, "_hold"}, l2 ? c2 : c0, exp);
   endtask

   initial begin
      logic [255:0] x, y;
      logic [255:0] hx[3];
      logic [255:0] hy[3];
      int           dcyc[3];
      int           nd, cyc, n, cnt;

      tbl[0] = '{1'b0, 256'd1, BV, {256'd0, BV}};
      tbl[1] = '{1'b0, ONES, ONES, (~512'd0 << 257) | 512'd1};
      tbl[2] = '{1'b1, ONES, ONES, (~512'd0 << 257) | 512'd1};
      tbl[3] = '{1'b0, 256'd0, ONES, 512'd0};
      tbl[4] = '{1'b0, 256'd1 << 64, 256'd1 << 192, 512'd1 << 256};
      tbl[5] = '{1'b0, 256'd3, 256'd5, 512'd15};
      tbl[6] = '{1'b1, 256'd1 << 255, 256'd1 << 255, 512'd1 << 510};
      tbl[7] = '{1'b0, ONES, 256'd2, {255'd0, {256{1'b1}}, 1'b0}};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy0", busy0, 0);
      check("rst_done0", done0, 0);
      check("rst_c0", c0, 0);
      check("rst_mul0", {ma0, mb0}, 0);
      check("rst_busy2", busy2, 0);
      check("rst_c2", c2, 0);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].l2, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1, $sformatf("vec%0d", i));
      end

      // start re-pulsed during ISSUE with new operands: must be ignored
      @(negedge clk);
      a = (256'd1 << 64) | 256'd1;
      b = (256'd1 << 64) | 256'd1;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      a = ONES;
      b = ONES;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      n = 6;
      while (!done0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done0) timeout("repulse_timeout");
      else begin
         check("repulse_lat", n, 17);
         check("repulse_c", c0, (512'd1 << 128) | (512'd1 << 65) | 512'd1);
      end
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy0 || done0) cnt++;
      end
      check("repulse_noqueue", cnt, 0);

      // Reset at k=7 aborts with no done
      @(negedge clk);
      a = ONES;
      b = ONES;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (7) @(negedge clk);
      check("k7_busy", busy0, 1);
      check("k7_mula", ma0, {64{1'b1}});
      rst_n = 1'b0;
      #1;
      check("k7rst_busy", busy0, 0);
      check("k7rst_done", done0, 0);
      check("k7rst_c", c0, 0);
      check("k7rst_mul", {ma0, mb0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (busy0 || done0) cnt++;
      end
      check("k7rst_nodone", cnt, 0);
      run_op(1'b0, 256'd5, 256'd7, 512'd35, 1'b1, "postrst");

      // start held high for three back-to-back operations
      hx[0] = ONES;                            hy[0] = ONES;
      hx[1] = (256'd1 << 200) | 256'd3;        hy[1] = 256'd1 << 100;
      hx[2] = 256'd12345;                      hy[2] = 256'd1;
      nd  = 0;
      cyc = 0;
      @(negedge clk);
      a = hx[0];
      b = hy[0];
      start0 = 1'b1;
      while (nd < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done0) begin
            dcyc[nd] = cyc;
            check($sformatf("held%0d_c", nd), c0, mul(hx[nd], hy[nd]));
            nd++;
            if (nd < 3) begin
               a = hx[nd];
               b = hy[nd];
            end else begin
               start0 = 1'b0;
            end
         end
      end
      start0 = 1'b0;
      if (nd < 3) timeout("held_timeout");
      else begin
         check("held_first", dcyc[0], 17);
         check("held_gap1", dcyc[1] - dcyc[0], 18);
         check("held_gap2", dcyc[2] - dcyc[1], 18);
      end
      repeat (3) @(negedge clk);

      // Random operands on the MUL_LAT=2 instance
      for (int i = 0; i < 1000; i++) begin
         x = rnd256();
         y = rnd256();
         run_op(1'b1, x, y, mul(x, y), (i < 2), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul256_sched.md
MUL256_SCHED -- requirements
Module: mul256_sched

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 0, meaning the cycles from mul_a/mul_b to a valid mul_p; legal range 0..4.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to multiply; sampled only in IDLE.
REQ-006 a  input  256  multiplicand, latched on start acceptance.
REQ-007 b  input  256  multiplier, latched on start acceptance.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when c holds the final product.
REQ-010 c  output  512  product accumulator.
REQ-011 mul_a  output  64  operand limb driven to the external 64x64 multiplier.
REQ-012 mul_b  output  64  operand limb driven to the external 64x64 multiplier.
REQ-013 mul_p  input  128  product returned by the external multiplier, equal to mul_a*mul_b from MUL_LAT cycles earlier (same cycle when MUL_LAT=0).

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE->ISSUE on a clk edge with start=1; at that edge the block latches a and b, clears c to 0 and sets issue index k=0.
REQ-016 In ISSUE, with i=k[3:2] and j=k[1:0], the block SHALL drive mul_a=a_lat[64i+63:64i] and mul_b=b_lat[64j+63:64j].
REQ-017 In ISSUE, k increments every cycle; after the k=15 cycle the FSM SHALL go to DRAIN if MUL_LAT>0, else to DONE.
REQ-018 DRAIN SHALL last exactly MUL_LAT cycles, then go to DONE.
REQ-019 Each issued (i,j) tag SHALL travel through a MUL_LAT-deep delay line with a valid bit; when a tag emerges, c <= c + (mul_p << 64*(i+j)), computed mod 2^512 (no overflow is possible).
REQ-020 In DONE, done=1 for exactly one cycle and c equals a_lat*b_lat exactly; the FSM then goes to IDLE.
REQ-021 Latency SHALL be fixed: with the acceptance edge as E0, done is high in cycle 17+MUL_LAT after E0, i.e. between edges E(16+MUL_LAT) and E(17+MUL_LAT).
REQ-022 start SHALL be ignored in ISSUE, DRAIN and DONE; no queuing.
REQ-023 With start held high, the next operation is accepted at the first edge in IDLE, giving one IDLE cycle between done and the new busy.
REQ-024 mul_a and mul_b SHALL be 0 outside ISSUE.
REQ-025 In IDLE, c SHALL hold the last result until the next acceptance; c is intermediate while busy.
REQ-026 Changes on a or b after acceptance SHALL have no effect on the running operation.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state=IDLE, busy=0, done=0, c=0, mul_a=0, mul_b=0, k=0, delay-line valids=0, a_lat=0, b_lat=0.
REQ-028 Reset in any state SHALL abort the operation with no done pulse; the first start after reset release behaves per REQ-015.

Verification
REQ-029 MUL_LAT=0, a=0x1, b=0xDEADBEEF_00000000_12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0_01234567_89ABCDEF -> done in cycle 17 and c=b zero-extended.
REQ-030 MUL_LAT=0, a=b=2^256-1 -> c=2^512-2^257+1 (all carry paths exercised).
REQ-031 MUL_LAT=2, random a and b (1000 pairs) -> done exactly 19 cycles after acceptance and c=a*b checked against a reference model.
REQ-032 start re-pulsed during ISSUE with different a -> ignored, and c matches the first operands.
REQ-033 rst_n low at k=7 -> all outputs 0 immediately, no done pulse; a new start after release gives a correct result.
REQ-034 start held high for 3 operations -> done pulses 18 cycles apart (MUL_LAT=0) and each c is correct.
